// File: rtl/aes_host_pkg.sv
// Shared types and constants for the byte-serial AES128 host initiator.
package aes_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } host_state_e;

    localparam int   BLOCK_BYTES = 16;
    localparam logic MODE_ENC    = 1'b1;
    localparam logic MODE_DEC    = 1'b0;

endpackage

// File: rtl/aes_byte_shift128.sv
// 128-bit byte shift register: bytes enter at [7:0] and leave from [127:120],
// with a byte counter and a flag marking a complete 16-byte block.
module aes_byte_shift128
    import aes_host_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [127:0]     load_data_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [127:0]     data_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

    logic [127:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;

    // The first shift of a new pass drops the full flag; the 16th raises it again.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clear_i) begin
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
            full_d = 1'b1;
        end else if (shift_i) begin
            data_d = {data_q[119:0], byte_i};
            if (cnt_q == LAST_BYTE) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '0) begin
                    full_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;
    assign full_o = full_q;

endmodule

// File: rtl/aes128_byte_host.sv
// Host-side initiator for the AES128 core: gathers key/text bytes, issues the
// block over ReadRy/ReadEn, collects Result over WriteRy/WriteEn, streams it out.
module aes128_byte_host
    import aes_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 4
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic [7:0]   InData,
    input  logic         InValid,
    input  logic         InIsKey,
    output logic         InReady,
    input  logic         ModeIn,
    output logic [7:0]   OutData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         ProgramSelector,
    output logic [127:0] UserText,
    output logic [127:0] Key,
    output logic         ReadyKey,
    output logic         ReadRy,
    input  logic         ReadEn,
    output logic         WriteRy,
    input  logic         WriteEn,
    input  logic [127:0] Result,
    output logic         Busy,
    output logic         Error
);

    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

    host_state_e      state_q, state_d;
    logic             read_ry_q, read_ry_d;
    logic             mode_q, mode_d;
    logic             error_q, error_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             in_load, key_take, txt_take, go_issue;
    logic             txt_clear, res_load, res_shift;
    logic [127:0]     key_data, txt_data, res_data;
    logic [119:0]     res_tail_unused;
    logic [CNT_W-1:0] key_cnt, res_cnt, txt_cnt_unused;
    logic             key_valid, txt_full, res_full_unused;

    // A key byte on the input in LOAD holds off issue so the key cannot change under the core.
    always_comb begin
        in_load  = (state_q == ST_LOAD);
        key_take = in_load && InValid && InIsKey;
        txt_take = in_load && InValid && !InIsKey && !txt_full;
        go_issue = in_load && txt_full && key_valid && (key_cnt == '0)
                   && !(InValid && InIsKey);
    end

    always_comb begin
        state_d   = state_q;
        read_ry_d = read_ry_q;
        mode_d    = mode_q;
        error_d   = error_q;
        timer_d   = '0;
        txt_clear = 1'b0;
        res_load  = 1'b0;
        res_shift = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (go_issue) begin
                    state_d = ST_ISSUE;
                    mode_d  = ModeIn ? MODE_ENC : MODE_DEC;
                end
            end
            ST_ISSUE: begin
                if (!read_ry_q) begin
                    read_ry_d = 1'b1;
                end else if (ReadEn) begin
                    read_ry_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (WriteEn) begin
                    res_load = 1'b1;
                    state_d  = ST_DRAIN;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMO_LAST)) begin
                    error_d   = 1'b1;
                    txt_clear = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (OutReady) begin
                    res_shift = 1'b1;
                    if (res_cnt == LAST_BYTE) begin
                        txt_clear = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q   <= ST_IDLE;
            read_ry_q <= 1'b0;
            mode_q    <= 1'b0;
            error_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            read_ry_q <= read_ry_d;
            mode_q    <= mode_d;
            error_q   <= error_d;
            timer_q   <= timer_d;
        end
    end

    aes_byte_shift128 #(.CNT_W(CNT_W)) u_key (
        .clk_i       (Clk),
        .rst_ni      (RstN),
        .clear_i     (1'b0),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (key_take),
        .byte_i      (InData),
        .data_o      (key_data),
        .cnt_o       (key_cnt),
        .full_o      (key_valid)
    );

    aes_byte_shift128 #(.CNT_W(CNT_W)) u_text (
        .clk_i       (Clk),
        .rst_ni      (RstN),
        .clear_i     (txt_clear),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (txt_take),
        .byte_i      (InData),
        .data_o      (txt_data),
        .cnt_o       (txt_cnt_unused),
        .full_o      (txt_full)
    );

    aes_byte_shift128 #(.CNT_W(CNT_W)) u_result (
        .clk_i       (Clk),
        .rst_ni      (RstN),
        .clear_i     (1'b0),
        .load_i      (res_load),
        .load_data_i (Result),
        .shift_i     (res_shift),
        .byte_i      (8'h00),
        .data_o      (res_data),
        .cnt_o       (res_cnt),
        .full_o      (res_full_unused)
    );

    assign res_tail_unused = res_data[119:0];

    assign InReady         = in_load && (InIsKey || !txt_full);
    assign ReadRy          = read_ry_q;
    assign WriteRy         = (state_q == ST_WAIT);
    assign OutValid        = (state_q == ST_DRAIN);
    assign OutData         = res_data[127:120];
    assign ProgramSelector = mode_q;
    assign UserText        = txt_data;
    assign Key             = key_data;
    assign ReadyKey        = key_valid;
    assign Busy            = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign Error           = error_q;

endmodule

// File: tb/tb_aes128_byte_host.sv
// Directed bench for aes128_byte_host: unit 0 uses the default timeout, unit 1 a short one.
module tb_aes128_byte_host;

  localparam int TMO_T = 8;
  localparam logic [127:0] K1 = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] T1 = 128'h328831e0435a3137f6309807a88da234;
  localparam logic [127:0] R1 = 128'h3902dc1925dc116a8409850b1dfb9732;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T3 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] R2 = 128'h0123456789abcdeffedcba9876543210;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]   in_data [2];
  logic         in_valid [2];
  logic         in_is_key [2];
  logic         in_ready [2];
  logic         mode_in [2];
  logic [7:0]   out_data [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         prog_sel [2];
  logic [127:0] user_text [2];
  logic [127:0] key [2];
  logic         ready_key [2];
  logic         read_ry [2];
  logic         read_en [2];
  logic         write_ry [2];
  logic         write_en [2];
  logic [127:0] result [2];
  logic         busy [2];
  logic         error_o [2];

  aes128_byte_host dut (
    .Clk(clk), .RstN(rst_n),
    .InData(in_data[0]), .InValid(in_valid[0]), .InIsKey(in_is_key[0]), .InReady(in_ready[0]),
    .ModeIn(mode_in[0]), .OutData(out_data[0]), .OutValid(out_valid[0]), .OutReady(out_ready[0]),
    .ProgramSelector(prog_sel[0]), .UserText(user_text[0]), .Key(key[0]), .ReadyKey(ready_key[0]),
    .ReadRy(read_ry[0]), .ReadEn(read_en[0]), .WriteRy(write_ry[0]), .WriteEn(write_en[0]),
    .Result(result[0]), .Busy(busy[0]), .Error(error_o[0])
  );

  aes128_byte_host #(.TIMEOUT_CYCLES(TMO_T)) dut_t (
    .Clk(clk), .RstN(rst_n),
    .InData(in_data[1]), .InValid(in_valid[1]), .InIsKey(in_is_key[1]), .InReady(in_ready[1]),
    .ModeIn(mode_in[1]), .OutData(out_data[1]), .OutValid(out_valid[1]), .OutReady(out_ready[1]),
    .ProgramSelector(prog_sel[1]), .UserText(user_text[1]), .Key(key[1]), .ReadyKey(ready_key[1]),
    .ReadRy(read_ry[1]), .ReadEn(read_en[1]), .WriteRy(write_ry[1]), .WriteEn(write_en[1]),
    .Result(result[1]), .Busy(busy[1]), .Error(error_o[1])
  );

  // scoreboard: {unit, byte} entries expected on OutData, in order
  logic [8:0]   exp_q[$];
  logic [127:0] exp_key [2];
  logic [127:0] exp_txt [2];
  logic         exp_mode [2];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // compare process: block contents at issue, result bytes at each transfer
  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        logic tag;
        logic [8:0] e;
        tag = (u == 1);
        if (read_en[u] && read_ry[u]) begin
          check("issue_key", key[u], exp_key[u]);
          check("issue_text", user_text[u], exp_txt[u]);
          check("issue_mode", prog_sel[u], exp_mode[u]);
        end
        if (write_en[u] && write_ry[u]) begin
          for (int i = 0; i < 16; i++) exp_q.push_back({tag, result[u][127-8*i -: 8]});
        end
        if (out_valid[u] && out_ready[u]) begin
          if (exp_q.size() == 0) note_fail("out_unexpected");
          else begin
            e = exp_q.pop_front();
            check("out_byte", {tag, out_data[u]}, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send_bytes(input int u, input logic [127:0] v, input logic is_key,
                            input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int n;
      n = 0;
      in_data[u]   = v[127-8*i -: 8];
      in_is_key[u] = is_key;
      in_valid[u]  = 1'b1;
      @(negedge clk);
      while (!in_ready[u] && n < 100) begin
        n++;
        @(negedge clk);
      end
      if (!in_ready[u]) note_fail("in_ready_wait");
      @(posedge clk); #1;
    end
    in_valid[u]  = 1'b0;
    in_is_key[u] = 1'b0;
  endtask

  task automatic issue(input int u);
    int n;
    n = 0;
    while (!read_ry[u] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!read_ry[u]) note_fail("read_ry_wait");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("read_ry_hold", read_ry[u], 1'b1);
    end
    read_en[u] = 1'b1;
    @(posedge clk); #1;
    read_en[u] = 1'b0;
    check("read_ry_drop", read_ry[u], 1'b0);
    check("write_ry_up", write_ry[u], 1'b1);
  endtask

  task automatic respond(input int u, input logic [127:0] res, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    check("write_ry_wait", write_ry[u], 1'b1);
    write_en[u] = 1'b1;
    result[u]   = res;
    @(posedge clk); #1;
    write_en[u] = 1'b0;
    check("write_ry_drop", write_ry[u], 1'b0);
    check("out_valid_up", out_valid[u], 1'b1);
  endtask

  task automatic drain(input int u, input bit toggle);
    int n;
    n = 0;
    out_ready[u] = 1'b1;
    while ((out_valid[u] || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (toggle) out_ready[u] = ~out_ready[u];
    end
    if (n >= 200) note_fail("drain_wait");
    out_ready[u] = 1'b1;
    check("drain_left", exp_q.size(), 0);
    check("drain_idle", {out_valid[u], busy[u]}, 2'b00);
  endtask

  task automatic check_all_zero(input int u, input string name);
    check({name, "_ctl"}, {in_ready[u], out_data[u], out_valid[u], prog_sel[u], ready_key[u],
                           read_ry[u], write_ry[u], busy[u], error_o[u]}, '0);
    check({name, "_key"}, key[u], '0);
    check({name, "_text"}, user_text[u], '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_ov;
    int cnt_rr;
    for (int u = 0; u < 2; u++) begin
      in_data[u] = '0; in_valid[u] = 1'b0; in_is_key[u] = 1'b0; mode_in[u] = 1'b0;
      out_ready[u] = 1'b1; read_en[u] = 1'b0; write_en[u] = 1'b0; result[u] = '0;
      exp_key[u] = '0; exp_txt[u] = '0; exp_mode[u] = 1'b0;
    end
    rst_n = 1'b0;
    #20;
    check_all_zero(0, "reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("load_in_ready", in_ready[0], 1'b1);

    // key then text, encrypt
    mode_in[0] = 1'b1;
    send_bytes(0, K1, 1'b1, 0, 16);
    exp_key[0] = K1;
    check("ready_key_set", ready_key[0], 1'b1);
    check("key_value", key[0], 128'h2b28ab097eaef7cf15d2154f16a6883c);
    send_bytes(0, T1, 1'b0, 0, 16);
    exp_txt[0]  = T1;
    exp_mode[0] = 1'b1;
    check("text_value", user_text[0], 128'h328831e0435a3137f6309807a88da234);
    check("latency_0", read_ry[0], 1'b0);
    @(posedge clk); #1;
    check("latency_1", read_ry[0], 1'b0);
    check("issue_busy", busy[0], 1'b1);
    check("prog_sel_enc", prog_sel[0], 1'b1);
    @(posedge clk); #1;
    check("latency_2", read_ry[0], 1'b1);

    // core model, full-rate drain
    issue(0);
    respond(0, R1, 10);
    check("first_out_byte", out_data[0], 8'h39);
    drain(0, 1'b0);

    // same again, decrypt, with a stuttering downstream
    mode_in[0] = 1'b0;
    send_bytes(0, T2, 1'b0, 0, 16);
    exp_txt[0]  = T2;
    exp_mode[0] = 1'b0;
    issue(0);
    respond(0, R1, 10);
    drain(0, 1'b1);

    // key reload mid-stream
    send_bytes(0, K2, 1'b1, 0, 1);
    check("reload_ready_key", ready_key[0], 1'b0);
    send_bytes(0, K2, 1'b1, 1, 5);
    send_bytes(0, T1, 1'b0, 0, 16);
    exp_txt[0] = T1;
    repeat (6) @(posedge clk);
    #1;
    check("reload_no_issue", {read_ry[0], busy[0], ready_key[0]}, 3'b000);
    send_bytes(0, K2, 1'b1, 5, 16);
    exp_key[0] = K2;
    issue(0);
    respond(0, R2, 3);
    drain(0, 1'b0);

    // reset during WAIT
    send_bytes(0, T1, 1'b0, 0, 16);
    issue(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero(0, "rst_wait");
    #11 rst_n = 1'b1;

    // reset mid-DRAIN
    mode_in[0] = 1'b1;
    send_bytes(0, K1, 1'b1, 0, 16);
    exp_key[0] = K1;
    send_bytes(0, T1, 1'b0, 0, 16);
    exp_txt[0]  = T1;
    exp_mode[0] = 1'b1;
    issue(0);
    respond(0, R1, 4);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("drain_partial", exp_q.size(), 11);
    rst_n = 1'b0;
    #1;
    check_all_zero(0, "rst_drain");
    exp_q.delete();
    #11 rst_n = 1'b1;
    cnt_ov = 0;
    cnt_rr = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) cnt_ov++;
      if (read_ry[0]) cnt_rr++;
    end
    check("post_rst_out_valid", cnt_ov, 0);
    check("post_rst_read_ry", cnt_rr, 0);
    check("post_rst_ready_key", ready_key[0], 1'b0);

    // text before key
    send_bytes(0, T3, 1'b0, 0, 16);
    exp_txt[0] = T3;
    in_data[0]   = 8'hee;
    in_is_key[0] = 1'b0;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("extra_text_stall", in_ready[0], 1'b0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    send_bytes(0, K1, 1'b1, 0, 15);
    check("no_issue_before_key", read_ry[0], 1'b0);
    send_bytes(0, K1, 1'b1, 15, 16);
    exp_key[0] = K1;
    issue(0);
    respond(0, R2, 2);
    drain(0, 1'b0);

    // timeout on the short-timeout unit
    mode_in[1] = 1'b1;
    send_bytes(1, K1, 1'b1, 0, 16);
    send_bytes(1, T1, 1'b0, 0, 16);
    exp_key[1]  = K1;
    exp_txt[1]  = T1;
    exp_mode[1] = 1'b1;
    issue(1);
    repeat (TMO_T - 1) @(posedge clk);
    #1;
    check("tmo_before", {error_o[1], write_ry[1]}, 2'b01);
    @(posedge clk); #1;
    check("tmo_error", error_o[1], 1'b1);
    check("tmo_state", {write_ry[1], busy[1], read_ry[1], ready_key[1], in_ready[1]}, 5'b00011);
    send_bytes(1, T3, 1'b0, 0, 16);
    exp_txt[1] = T3;
    issue(1);
    respond(1, R2, 2);
    drain(1, 1'b0);
    check("tmo_sticky", error_o[1], 1'b1);
    check("unit0_no_error", error_o[0], 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
